// File: rtl/uart_alu_frontend.sv
`default_nettype none
// ============================================================================
// Module  : uart_alu_frontend
// Brief   : Builds ALU operands/opcode from UART RX bytes (MSB first), strobes
//           the ALU, and streams the result back MSB first over UART TX.
// Rev     : 1.0
// ============================================================================
module uart_alu_frontend #(
    parameter int NB_DATA     = 8,
    parameter int NB_OP       = 6,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic               o_alu_valid,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_error
);
    localparam int c_N_BYTES = NB_DATA / 8;
    localparam int c_BC_W    = (c_N_BYTES > 1) ? $clog2(c_N_BYTES) : 1;
    localparam int c_TO_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [c_BC_W-1:0] c_LAST_BYTE = c_BC_W'(c_N_BYTES - 1);
    localparam logic [c_TO_W-1:0] c_TO_MAX    = c_TO_W'(TIMEOUT_CYC);

    localparam logic [2:0] c_S_WAIT_A  = 3'd0;
    localparam logic [2:0] c_S_WAIT_B  = 3'd1;
    localparam logic [2:0] c_S_WAIT_OP = 3'd2;
    localparam logic [2:0] c_S_EXEC    = 3'd3;
    localparam logic [2:0] c_S_SEND    = 3'd4;
    localparam logic [2:0] c_S_WAIT_TX = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [NB_DATA-1:0] r_data_a;
    logic [NB_DATA-1:0] r_data_b;
    logic [NB_OP-1:0]   r_op;
    logic [NB_DATA-1:0] r_tx_shift;
    logic [c_BC_W-1:0]  r_byte_cnt;
    logic [c_TO_W-1:0]  r_to_cnt;

    logic w_rx_phase;
    logic w_accept;
    logic w_partial;
    logic w_timeout;
    logic w_last;

    assign w_rx_phase = (r_state == c_S_WAIT_A) || (r_state == c_S_WAIT_B) ||
                        (r_state == c_S_WAIT_OP);
    assign w_accept   = i_rx_done && w_rx_phase;
    assign w_partial  = ((r_state == c_S_WAIT_A) && (r_byte_cnt != '0)) ||
                        (r_state == c_S_WAIT_B) || (r_state == c_S_WAIT_OP);
    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign w_timeout  = (TIMEOUT_CYC != 0) && w_partial && !i_rx_done &&
                        (r_to_cnt == c_TO_MAX);
    assign w_last     = (r_byte_cnt == c_LAST_BYTE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_S_WAIT_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_WAIT_A: begin
                if (w_timeout)                  w_next_state = c_S_WAIT_A;
                else if (i_rx_done && w_last)   w_next_state = c_S_WAIT_B;
            end
            c_S_WAIT_B: begin
                if (w_timeout)                  w_next_state = c_S_WAIT_A;
                else if (i_rx_done && w_last)   w_next_state = c_S_WAIT_OP;
            end
            c_S_WAIT_OP: begin
                if (w_timeout)                  w_next_state = c_S_WAIT_A;
                else if (i_rx_done)             w_next_state = c_S_EXEC;
            end
            c_S_EXEC:                           w_next_state = c_S_SEND;
            c_S_SEND:                           w_next_state = c_S_WAIT_TX;
            c_S_WAIT_TX: begin
                if (i_tx_done)                  w_next_state = w_last ? c_S_WAIT_A : c_S_SEND;
            end
            default:                            w_next_state = c_S_WAIT_A;
        endcase
    end

    always_comb begin
        o_alu_valid = (r_state == c_S_EXEC);
        o_tx_start  = (r_state == c_S_SEND);
        o_busy      = (r_state == c_S_EXEC) || (r_state == c_S_SEND) ||
                      (r_state == c_S_WAIT_TX);
        o_error     = w_timeout;
        o_tx_data   = 8'h00;
        if ((r_state == c_S_SEND) || (r_state == c_S_WAIT_TX)) begin
            o_tx_data = r_tx_shift[NB_DATA-1 -: 8];
        end
    end

    // Byte counter doubles as RX byte index and TX byte index.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data_a   <= '0;
            r_data_b   <= '0;
            r_op       <= '0;
            r_tx_shift <= '0;
            r_byte_cnt <= '0;
        end else begin
            case (r_state)
                c_S_WAIT_A: begin
                    if (i_rx_done) begin
                        r_data_a   <= NB_DATA'({r_data_a, i_rx_data});
                        r_byte_cnt <= w_last ? '0 : r_byte_cnt + 1'b1;
                    end else if (w_timeout) begin
                        r_byte_cnt <= '0;
                    end
                end
                c_S_WAIT_B: begin
                    if (i_rx_done) begin
                        r_data_b   <= NB_DATA'({r_data_b, i_rx_data});
                        r_byte_cnt <= w_last ? '0 : r_byte_cnt + 1'b1;
                    end else if (w_timeout) begin
                        r_byte_cnt <= '0;
                    end
                end
                c_S_WAIT_OP: begin
                    if (i_rx_done) begin
                        r_op       <= i_rx_data[NB_OP-1:0];
                        r_byte_cnt <= '0;
                    end else if (w_timeout) begin
                        r_byte_cnt <= '0;
                    end
                end
                c_S_EXEC: begin
                    r_tx_shift <= i_alu_result;
                end
                c_S_WAIT_TX: begin
                    if (i_tx_done) begin
                        r_byte_cnt <= w_last ? '0 : r_byte_cnt + 1'b1;
                        r_tx_shift <= r_tx_shift << 8;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= '0;
        end else if (w_accept || !w_partial || w_timeout) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != c_TO_MAX) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign o_data_a = r_data_a;
    assign o_data_b = r_data_b;
    assign o_op     = r_op;

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_frontend.sv
`default_nettype none
// Bench for uart_alu_frontend: 8-bit and 16-bit instances checked every cycle
// against a command-level model, plus directed scenarios with literal expectations.
module tb_uart_alu_frontend;
    localparam int c_TO = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] rxd [2];
    logic       rxv [2];
    logic       txd0, txd1;

    logic [7:0]  a0, b0, alu0, txdata0;
    logic [5:0]  op0, op1;
    logic [15:0] a1, b1, alu1;
    logic [7:0]  txdata1;
    logic        val0, st0, busy0, err0;
    logic        val1, st1, busy1, err1;

    function automatic logic [15:0] alu(input logic [15:0] a, input logic [15:0] b,
                                        input logic [7:0] op);
        case (op)
            8'h20:   return a + b;
            8'h22:   return a - b;
            8'h24:   return a & b;
            8'h25:   return a | b;
            default: return 16'h0000;
        endcase
    endfunction

    assign alu0 = 8'(alu({8'h00, a0}, {8'h00, b0}, {2'b00, op0}));
    assign alu1 = alu(a1, b1, {2'b00, op1});

    uart_alu_frontend #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYC(c_TO)) u8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rxd[0]), .i_rx_done(rxv[0]),
        .i_alu_result(alu0), .o_data_a(a0), .o_data_b(b0), .o_op(op0),
        .o_alu_valid(val0), .o_tx_data(txdata0), .o_tx_start(st0),
        .i_tx_done(txd0), .o_busy(busy0), .o_error(err0));

    uart_alu_frontend #(.NB_DATA(16), .NB_OP(6), .TIMEOUT_CYC(c_TO)) u16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rxd[1]), .i_rx_done(rxv[1]),
        .i_alu_result(alu1), .o_data_a(a1), .o_data_b(b1), .o_op(op1),
        .o_alu_valid(val1), .o_tx_data(txdata1), .o_tx_start(st1),
        .i_tx_done(txd1), .o_busy(busy1), .o_error(err1));

    logic [15:0] v_a [2], v_b [2];
    logic [7:0]  v_op [2], v_txd [2];
    logic        v_valid [2], v_start [2], v_busy [2], v_err [2], v_txdone [2];
    assign v_a[0] = {8'h00, a0};      assign v_a[1] = a1;
    assign v_b[0] = {8'h00, b0};      assign v_b[1] = b1;
    assign v_op[0] = {2'b00, op0};    assign v_op[1] = {2'b00, op1};
    assign v_txd[0] = txdata0;        assign v_txd[1] = txdata1;
    assign v_valid[0] = val0;         assign v_valid[1] = val1;
    assign v_start[0] = st0;          assign v_start[1] = st1;
    assign v_busy[0] = busy0;         assign v_busy[1] = busy1;
    assign v_err[0] = err0;           assign v_err[1] = err1;
    assign v_txdone[0] = txd0;        assign v_txdone[1] = txd1;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Command-level model: bytes collected per command, cycle of last accepted byte,
    // pending result bytes and the cycles at which strobes are due.
    int          nb [2], last [2], vcyc [2], scyc [2], left [2], errs [2], starts [2];
    logic [15:0] ma [2], mb [2], mres [2];
    logic [7:0]  mop [2];
    bit          mbusy [2];
    logic        m_err;
    int          nby;
    logic [15:0] mask;

    initial begin
        for (int s = 0; s < 2; s++) begin
            nb[s] = 0; last[s] = 0; vcyc[s] = 0; scyc[s] = 0; left[s] = 0;
            errs[s] = 0; starts[s] = 0; ma[s] = 0; mb[s] = 0; mres[s] = 0;
            mop[s] = 0; mbusy[s] = 0;
        end
    end

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (!rst_n) begin
                check($sformatf("rst_a[%0d]", s), v_a[s], 16'h0);
                check($sformatf("rst_b[%0d]", s), v_b[s], 16'h0);
                check($sformatf("rst_op[%0d]", s), 16'(v_op[s]), 16'h0);
                check($sformatf("rst_txdata[%0d]", s), 16'(v_txd[s]), 16'h0);
                check($sformatf("rst_outs[%0d]", s),
                      16'({v_valid[s], v_start[s], v_busy[s], v_err[s]}), 16'h0);
                nb[s] = 0; ma[s] = 0; mb[s] = 0; mop[s] = 0; mres[s] = 0;
                mbusy[s] = 0; left[s] = 0;
            end else begin
                nby  = (s == 0) ? 1 : 2;
                mask = (s == 0) ? 16'h00FF : 16'hFFFF;
                m_err = !mbusy[s] && (nb[s] > 0) && !rxv[s] && (cyc - last[s] == c_TO + 1);
                check($sformatf("error[%0d]", s), 16'(v_err[s]), 16'(m_err));
                check($sformatf("alu_valid[%0d]", s), 16'(v_valid[s]),
                      16'(mbusy[s] && cyc == vcyc[s]));
                check($sformatf("tx_start[%0d]", s), 16'(v_start[s]),
                      16'(mbusy[s] && cyc == scyc[s]));
                check($sformatf("busy[%0d]", s), 16'(v_busy[s]), 16'(mbusy[s]));
                check($sformatf("data_a[%0d]", s), v_a[s], ma[s]);
                check($sformatf("data_b[%0d]", s), v_b[s], mb[s]);
                check($sformatf("op[%0d]", s), 16'(v_op[s]), 16'(mop[s]));
                if (mbusy[s] && cyc >= scyc[s])
                    check($sformatf("tx_data[%0d]", s), 16'(v_txd[s]),
                          16'(8'(mres[s] >> (8 * (left[s] - 1)))));
                if (v_err[s]) errs[s]++;
                if (v_start[s]) starts[s]++;

                if (m_err) begin
                    nb[s] = 0;
                end else if (rxv[s] && !mbusy[s]) begin
                    last[s] = cyc;
                    if (nb[s] < nby) begin
                        ma[s] = ((ma[s] << 8) | {8'h00, rxd[s]}) & mask;
                        nb[s]++;
                    end else if (nb[s] < 2 * nby) begin
                        mb[s] = ((mb[s] << 8) | {8'h00, rxd[s]}) & mask;
                        nb[s]++;
                    end else begin
                        mop[s]   = rxd[s] & 8'h3F;
                        mres[s]  = alu(ma[s], mb[s], mop[s]) & mask;
                        mbusy[s] = 1'b1;
                        vcyc[s]  = cyc + 1;
                        scyc[s]  = cyc + 2;
                        left[s]  = nby;
                        nb[s]    = 0;
                    end
                end
                if (mbusy[s] && v_txdone[s] && cyc >= scyc[s]) begin
                    left[s]--;
                    if (left[s] == 0) mbusy[s] = 1'b0;
                    else              scyc[s]  = cyc + 1;
                end
            end
        end
    end

    // UART TX stand-in: finishes each byte three cycles after its start strobe.
    always begin
        @(negedge clk);
        if (rst_n && st0) begin
            repeat (3) @(posedge clk);
            #1;
            if (rst_n) begin
                txd0 = 1'b1;
                @(posedge clk); #1;
                txd0 = 1'b0;
            end
        end
    end

    always begin
        @(negedge clk);
        if (rst_n && st1) begin
            repeat (3) @(posedge clk);
            #1;
            if (rst_n) begin
                txd1 = 1'b1;
                @(posedge clk); #1;
                txd1 = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input logic [7:0] b);
        rxd[s] = b;
        rxv[s] = 1'b1;
        tick();
        rxv[s] = 1'b0;
    endtask

    task automatic wait_tx(input int s, input logic [7:0] exp, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (v_start[s]) begin
                seen = 1'b1;
                check(name, 16'(v_txd[s]), 16'(exp));
            end
        end
        check({name, "_started"}, 16'(seen), 16'h1);
        tick();
    endtask

    task automatic wait_idle(input int s, input string name);
        bit idle = 1'b0;
        for (int i = 0; i < 60 && !idle; i++) begin
            @(negedge clk);
            if (!v_busy[s]) idle = 1'b1;
        end
        check(name, 16'(idle), 16'h1);
        tick();
    endtask

    int e0, st;

    initial begin
        rst_n = 1'b1;
        rxd[0] = 8'h00; rxd[1] = 8'h00; rxv[0] = 1'b0; rxv[1] = 1'b0;
        txd0 = 1'b0; txd1 = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // 8-bit ADD: 5 + 3
        send(0, 8'h05); send(0, 8'h03); send(0, 8'h20);
        @(negedge clk);
        check("t1_alu_valid", 16'(val0), 16'h1);
        wait_tx(0, 8'h08, "t1_tx");
        wait_idle(0, "t1_idle");

        // 16-bit ADD: 0x1234 + 0x0001, two result bytes
        send(1, 8'h12); send(1, 8'h34); send(1, 8'h00); send(1, 8'h01); send(1, 8'h20);
        @(negedge clk);
        check("t2_a", a1, 16'h1234);
        check("t2_b", b1, 16'h0001);
        wait_tx(1, 8'h12, "t2_tx0");
        wait_tx(1, 8'h35, "t2_tx1");
        wait_idle(1, "t2_idle");

        // Timeout drops a partial command
        e0 = errs[0];
        send(0, 8'h05);
        repeat (110) tick();
        check("t3_err_count", 16'(errs[0] - e0), 16'd1);
        send(0, 8'h02); send(0, 8'h02); send(0, 8'h20);
        wait_tx(0, 8'h04, "t3_tx");
        wait_idle(0, "t3_idle");

        // Byte on the expiry cycle is accepted
        e0 = errs[0];
        send(0, 8'h07);
        repeat (100) tick();
        send(0, 8'h03);
        send(0, 8'h20);
        check("t4_err_count", 16'(errs[0] - e0), 16'd0);
        wait_tx(0, 8'h0A, "t4_tx");
        wait_idle(0, "t4_idle");

        // RX byte during WAIT_TX is dropped
        send(0, 8'h04); send(0, 8'h03); send(0, 8'h22);
        wait_tx(0, 8'h01, "t5_tx");
        st = starts[0];
        send(0, 8'hFF);
        @(negedge clk);
        check("t5_a", 16'(a0), 16'h0004);
        check("t5_b", 16'(b0), 16'h0003);
        check("t5_op", 16'(op0), 16'h0022);
        wait_idle(0, "t5_idle");
        repeat (10) tick();
        check("t5_no_extra_tx", 16'(starts[0] - st), 16'd0);

        // Reset while the first of two result bytes is in flight
        send(1, 8'hAB); send(1, 8'hCD); send(1, 8'h11); send(1, 8'h11); send(1, 8'h20);
        wait_tx(1, 8'hBC, "t6_tx0");
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_a", a1, 16'h0000);
        check("t6_rst_outs", 16'({st1, busy1, val1, err1}), 16'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        st = starts[1];
        repeat (20) tick();
        check("t6_no_tx_after_rst", 16'(starts[1] - st), 16'd0);
        send(1, 8'h00); send(1, 8'h02); send(1, 8'h00); send(1, 8'h03); send(1, 8'h20);
        wait_tx(1, 8'h00, "t6_tx_new0");
        wait_tx(1, 8'h05, "t6_tx_new1");
        wait_idle(1, "t6_idle");

        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
